// File: rtl/ad9783_cfg_sequencer.sv
// Power-up configuration sequencer and host command arbiter for the AD9783 command port.
// Clean init latency from reset release to ready_out: RST_HOLD + 8*(SPI_WAIT+2) + 4 cycles.
module ad9783_cfg_sequencer #(
   parameter int unsigned RST_HOLD  = 16,
   parameter int unsigned SPI_WAIT  = 40,
   parameter int unsigned MAX_RETRY = 2,
   parameter logic [31:0] INIT0     = 32'h0000_0000,
   parameter logic [31:0] INIT1     = 32'h0002_0000,
   parameter logic [31:0] INIT2     = 32'h0003_0000,
   parameter logic [31:0] INIT3     = 32'h0004_0000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        reinit_in,
   input  logic        host_req_in,
   input  logic [15:0] host_addr_in,
   input  logic [15:0] host_data_in,
   output logic        host_ack_out,
   output logic [15:0] host_rdata_out,
   output logic        cmd_trig_out,
   output logic [15:0] cmd_addr_out,
   output logic [15:0] cmd_data_out,
   input  logic [15:0] cmd_rdata_in,
   output logic        dac_rst_out,
   input  logic [15:0] dac0_in,
   input  logic [15:0] dac1_in,
   output logic [15:0] dac0_out,
   output logic [15:0] dac1_out,
   output logic        ready_out,
   output logic        fault_out
);

   localparam int unsigned CntMax = (RST_HOLD > SPI_WAIT) ? RST_HOLD : SPI_WAIT;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      StRstHold,
      StWrIssue,
      StWrWait,
      StRdIssue,
      StRdWait,
      StCheck,
      StReady,
      StHostWait,
      StFault
   } state_e;

   state_e            state;
   logic [CntW-1:0]   cnt;
   logic [1:0]        idx;
   logic [RetryW-1:0] retry;
   logic [7:0]        rd_sample;
   logic              reinit_pend;

   logic [31:0]       entry;
   logic [RetryW-1:0] retry_inc;
   logic              hold_done;
   logic              wait_done;

   always_comb begin
      entry = INIT0;
      unique case (idx)
         2'd0: entry = INIT0;
         2'd1: entry = INIT1;
         2'd2: entry = INIT2;
         2'd3: entry = INIT3;
      endcase
      retry_inc = retry + 1'b1;
      hold_done = (cnt == CntW'(RST_HOLD - 1));
      // Counter is cleared in the trig cycle, so this is trig + SPI_WAIT.
      wait_done = (cnt == CntW'(SPI_WAIT));
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= StRstHold;
         cnt            <= '0;
         idx            <= 2'd0;
         retry          <= '0;
         rd_sample      <= 8'h00;
         reinit_pend    <= 1'b0;
         dac_rst_out    <= 1'b1;
         ready_out      <= 1'b0;
         fault_out      <= 1'b0;
         cmd_trig_out   <= 1'b0;
         host_ack_out   <= 1'b0;
         cmd_addr_out   <= 16'h0000;
         cmd_data_out   <= 16'h0000;
         host_rdata_out <= 16'h0000;
         dac0_out       <= 16'h8000;
         dac1_out       <= 16'h8000;
      end else begin
         cmd_trig_out <= 1'b0;
         host_ack_out <= 1'b0;
         dac0_out     <= ready_out ? dac0_in : 16'h8000;
         dac1_out     <= ready_out ? dac1_in : 16'h8000;

         case (state)
            StRstHold: begin
               if (hold_done) begin
                  dac_rst_out <= 1'b0;
                  cnt         <= '0;
                  state       <= StWrIssue;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StWrIssue: begin
               cmd_addr_out <= {1'b0, entry[30:16]};
               cmd_data_out <= entry[15:0];
               cmd_trig_out <= 1'b1;
               cnt          <= '0;
               state        <= StWrWait;
            end

            StWrWait: begin
               if (wait_done) begin
                  cnt <= '0;
                  idx <= idx + 2'd1;
                  state <= (idx == 2'd3) ? StRdIssue : StWrIssue;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StRdIssue: begin
               cmd_addr_out <= entry[31:16] | 16'h8000;
               cmd_data_out <= 16'h0000;
               cmd_trig_out <= 1'b1;
               cnt          <= '0;
               state        <= StRdWait;
            end

            StRdWait: begin
               if (wait_done) begin
                  rd_sample <= cmd_rdata_in[7:0];
                  cnt       <= '0;
                  state     <= StCheck;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StCheck: begin
               if (rd_sample == entry[7:0]) begin
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     ready_out <= 1'b1;
                     state     <= StReady;
                  end else begin
                     state <= StRdIssue;
                  end
               end else begin
                  idx   <= 2'd0;
                  retry <= retry_inc;
                  if (retry_inc > RetryW'(MAX_RETRY)) begin
                     fault_out <= 1'b1;
                     state     <= StFault;
                  end else begin
                     dac_rst_out <= 1'b1;
                     cnt         <= '0;
                     state       <= StRstHold;
                  end
               end
            end

            StReady: begin
               if (reinit_in || reinit_pend) begin
                  reinit_pend <= 1'b0;
                  retry       <= '0;
                  ready_out   <= 1'b0;
                  dac_rst_out <= 1'b1;
                  cnt         <= '0;
                  idx         <= 2'd0;
                  state       <= StRstHold;
               end else if (host_req_in && !host_ack_out) begin
                  // The ack cycle is skipped so a host holding req one cycle past ack is not re-served.
                  cmd_addr_out <= host_addr_in;
                  cmd_data_out <= host_data_in;
                  cmd_trig_out <= 1'b1;
                  cnt          <= '0;
                  state        <= StHostWait;
               end
            end

            StHostWait: begin
               if (reinit_in) begin
                  reinit_pend <= 1'b1;
               end
               if (wait_done) begin
                  host_rdata_out <= cmd_rdata_in;
                  host_ack_out   <= 1'b1;
                  cnt            <= '0;
                  state          <= StReady;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            StFault: begin
               if (reinit_in) begin
                  fault_out   <= 1'b0;
                  retry       <= '0;
                  dac_rst_out <= 1'b1;
                  cnt         <= '0;
                  idx         <= 2'd0;
                  state       <= StRstHold;
               end
            end

            default: begin
               state <= StRstHold;
            end
         endcase
      end
   end

endmodule
